mac_seq_ctrl: RTL and testbench

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

---
 rtl/mac_seq_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequencer for a 4-lane MAC datapath computing one dot product.
//
// Flow for a run of N chunks accepted in cycle 0:
//   cycles 1..N     : RUN issues reads for chunks 0..N-1 (mem_ren, mem_addr)
//   cycles 2..N+1   : memory returns mem_x/mem_w (one cycle after each read)
//   cycles 3..N+2   : operand stage drives x_out/w_out; accumulator takes mac_out
//   cycle  N+3      : DONE, one-cycle done pulse, result valid
// An N=0 run goes straight from IDLE to DONE and reports done in cycle 1.
//
// Handshake: start is a request sampled only in IDLE; busy is high in every
// other state, and any start seen while busy is dropped. There is no
// back-pressure on the memory side: read data is always accepted the cycle
// it returns.
//
// Optional feature: define PSUM_INIT_EN to add the psum_init input, which
// preloads the accumulator on an accepted start instead of clearing it.
//
// state_dbg exposes the FSM encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3).

module mac_seq_ctrl #(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int len_bw  = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [len_bw-1:0]   num_chunks,
`ifdef PSUM_INIT_EN
    input  logic [psum_bw-1:0]  psum_init,
`endif
    output logic                mem_ren,
    output logic [len_bw-1:0]   mem_addr,
    input  logic [4*bw-1:0]     mem_x,
    input  logic [4*bw-1:0]     mem_w,
    output logic [4*bw-1:0]     x_out,
    output logic [4*bw-1:0]     w_out,
    output logic [psum_bw-1:0]  psum_fb,
    input  logic [psum_bw-1:0]  mac_out,
    output logic                busy,
    output logic                done,
    output logic [psum_bw-1:0]  result,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [len_bw-1:0] LEN_ONE = len_bw'(1);

    state_t                state;
    state_t                next_state;

    logic [len_bw-1:0]     addr_q;       // next chunk address to read
    logic [len_bw-1:0]     n_q;          // chunk count latched at acceptance
    logic                  rd_valid;     // a read was issued last cycle; data is on mem_x/mem_w now
    logic                  stage_valid;  // operand stage holds a chunk this cycle
    logic [4*bw-1:0]       x_q;
    logic [4*bw-1:0]       w_q;
    logic [psum_bw-1:0]    acc_q;
    logic [psum_bw-1:0]    result_q;
    logic [psum_bw-1:0]    acc_init;
    logic                  accept;
    logic                  last_read;
    logic                  enter_done;

`ifdef PSUM_INIT_EN
    assign acc_init = psum_init;
`else
    assign acc_init = '0;
`endif

    // A start only counts when the FSM is idle; reset priority comes from
    // the register blocks testing reset first.
    assign accept     = (state == IDLE) && start;
    assign last_read  = (state == RUN) && (addr_q == (n_q - LEN_ONE));
    assign enter_done = (next_state == DONE) && (state != DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and control outputs. DRAIN waits until the final read's
    // data has moved into the operand stage; that chunk is summed in the
    // same cycle the FSM advances to DONE.
    always_comb begin
        next_state = state;
        mem_ren    = 1'b0;
        done       = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_chunks == '0) begin
                        next_state = DONE;
                    end else begin
                        next_state = RUN;
                    end
                end
            end
            RUN: begin
                mem_ren = 1'b1;
                if (last_read) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (!rd_valid) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Read address counter and latched chunk count; num_chunks is only
    // looked at on acceptance so later changes have no effect.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q <= '0;
            n_q    <= '0;
        end else if (accept) begin
            addr_q <= '0;
            n_q    <= num_chunks;
        end else if (state == RUN) begin
            addr_q <= addr_q + LEN_ONE;
        end
    end

    // Memory-return valid and operand stage. Invalid cycles load zeros so
    // the datapath never sees stale or undriven memory data.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid    <= 1'b0;
            stage_valid <= 1'b0;
            x_q         <= '0;
            w_q         <= '0;
        end else begin
            rd_valid    <= mem_ren;
            stage_valid <= rd_valid;
            x_q         <= rd_valid ? mem_x : '0;
            w_q         <= rd_valid ? mem_w : '0;
        end
    end

    // Accumulator: seeded on acceptance, takes the datapath sum on every
    // valid stage cycle (wrapping naturally at psum_bw bits).
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else if (accept) begin
            acc_q <= acc_init;
        end else if (stage_valid) begin
            acc_q <= mac_out;
        end
    end

    // Result register, loaded on the way into DONE and held afterwards.
    // From IDLE (N=0) it takes the seed value; from DRAIN it takes the
    // value the accumulator is about to hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
        end else if (enter_done) begin
            if (state == IDLE) begin
                result_q <= acc_init;
            end else if (stage_valid) begin
                result_q <= mac_out;
            end else begin
                result_q <= acc_q;
            end
        end
    end

    assign mem_addr  = (state == RUN) ? addr_q : '0;
    assign x_out     = x_q;
    assign w_out     = w_q;
    assign psum_fb   = acc_q;
    assign result    = result_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: table of directed dot-product runs plus hand
// sequences for stray start, reset mid-run and reset/start collision.
// Build with +define+PSUM_INIT_EN to include the psum_init vectors.

module tb_mac_seq_ctrl;

    localparam int BW      = 4;
    localparam int PSUM_BW = 12;
    localparam int LEN_BW  = 6;

    logic                clk;
    logic                reset;
    logic                start;
    logic [LEN_BW-1:0]   num_chunks;
    logic                mem_ren;
    logic [LEN_BW-1:0]   mem_addr;
    logic [4*BW-1:0]     mem_x;
    logic [4*BW-1:0]     mem_w;
    logic [4*BW-1:0]     x_out;
    logic [4*BW-1:0]     w_out;
    logic [PSUM_BW-1:0]  psum_fb;
    logic [PSUM_BW-1:0]  mac_out;
    logic                busy;
    logic                done;
    logic [PSUM_BW-1:0]  result;
    logic [1:0]          state_dbg;
`ifdef PSUM_INIT_EN
    logic [PSUM_BW-1:0]  psum_init;
`endif

    logic [4*BW-1:0]     cur_x;
    logic [4*BW-1:0]     cur_w;
    logic [31:0]         mac_sum;

    int n_cmp;
    int n_err;

    mac_seq_ctrl #(
        .bw      (BW),
        .psum_bw (PSUM_BW),
        .len_bw  (LEN_BW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .num_chunks (num_chunks),
`ifdef PSUM_INIT_EN
        .psum_init  (psum_init),
`endif
        .mem_ren    (mem_ren),
        .mem_addr   (mem_addr),
        .mem_x      (mem_x),
        .mem_w      (mem_w),
        .x_out      (x_out),
        .w_out      (w_out),
        .psum_fb    (psum_fb),
        .mac_out    (mac_out),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .state_dbg  (state_dbg)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Operand memory: every chunk holds cur_x/cur_w; unread cycles return junk.
    always @(posedge clk) begin
        if (mem_ren) begin
            mem_x <= cur_x;
            mem_w <= cur_w;
        end else begin
            mem_x <= 16'($urandom);
            mem_w <= 16'($urandom);
        end
    end

    // 4-lane MAC datapath model.
    always_comb begin
        mac_sum = 32'(psum_fb);
        for (int i = 0; i < 4; i++) begin
            mac_sum = mac_sum + 32'(x_out[i*BW +: BW]) * 32'(w_out[i*BW +: BW]);
        end
        mac_out = mac_sum[PSUM_BW-1:0];
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Starts one run and checks every cycle up to two past the expected done.
    // A stray start with num_chunks=5 is driven in cycle 'stray' (0 = none).
    task automatic run_vec(input string name, input int n, input logic [15:0] xv,
                           input logic [15:0] wv, input int exp_res,
                           input int exp_done, input int stray);
        @(negedge clk);
        cur_x      = xv;
        cur_w      = wv;
        start      = 1'b1;
        num_chunks = LEN_BW'(n);
        for (int c = 1; c <= exp_done + 2; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start      = 1'b0;
                num_chunks = LEN_BW'($urandom_range(0, 63));
            end
            if (c == stray + 1) start = 1'b0;
            check({name, " ren"}, int'(mem_ren), int'(c <= n));
            if (c <= n) check({name, " addr"}, int'(mem_addr), c - 1);
            if (c >= 3 && c <= n + 2) begin
                check({name, " x_out"}, int'(x_out), int'(xv));
                check({name, " w_out"}, int'(w_out), int'(wv));
            end else begin
                check({name, " x_out idle"}, int'(x_out), 0);
            end
            check({name, " done"}, int'(done), int'(c == exp_done));
            check({name, " busy"}, int'(busy), int'(c <= exp_done));
            if (c >= exp_done) check({name, " result"}, int'(result), exp_res);
            if (c == stray) begin
                start      = 1'b1;
                num_chunks = LEN_BW'(5);
            end
        end
        start = 1'b0;
    endtask

    typedef struct {
        string       name;
        int          n;
        logic [15:0] xv;
        logic [15:0] wv;
        int          exp_res;
        int          exp_done;
    } vec_t;

    vec_t vecs[8];

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;

        vecs[0] = '{"n1_ones",   1,  16'h1111, 16'h1111,    4,  4};
        vecs[1] = '{"n3_2x3",    3,  16'h2222, 16'h3333,   72,  6};
        vecs[2] = '{"n0",        0,  16'h5555, 16'h5555,    0,  1};
        vecs[3] = '{"n5_7x9",    5,  16'h7777, 16'h9999, 1260,  8};
        vecs[4] = '{"n20_wrap",  20, 16'hFFFF, 16'hFFFF, 1616, 23};
        vecs[5] = '{"n63_max",   63, 16'h1111, 16'hFFFF, 3780, 66};
        vecs[6] = '{"n2_lanes",  2,  16'h4321, 16'h1111,   20,  5};
        vecs[7] = '{"n2_zero_x", 2,  16'h0000, 16'h9999,    0,  5};

        // Clock/reset block.
        reset      = 1'b1;
        start      = 1'b0;
        num_chunks = '0;
        cur_x      = '0;
        cur_w      = '0;
`ifdef PSUM_INIT_EN
        psum_init  = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst ren",    int'(mem_ren),   0);
        check("rst addr",   int'(mem_addr),  0);
        check("rst x_out",  int'(x_out),     0);
        check("rst w_out",  int'(w_out),     0);
        check("rst psum",   int'(psum_fb),   0);
        check("rst busy",   int'(busy),      0);
        check("rst done",   int'(done),      0);
        check("rst result", int'(result),    0);
        check("rst state",  int'(state_dbg), 0);
        reset = 1'b0;

        // Table-driven runs.
        for (int v = 0; v < 8; v++) begin
            run_vec(vecs[v].name, vecs[v].n, vecs[v].xv, vecs[v].wv,
                    vecs[v].exp_res, vecs[v].exp_done, 0);
        end

        // Start pulsed in cycle 2 of an N=3 run is ignored.
        run_vec("stray_run", 3, 16'h2222, 16'h3333, 72, 6, 2);
        // Start pulsed during the DONE cycle is ignored too.
        run_vec("stray_done", 1, 16'h1111, 16'h1111, 4, 4, 4);

        // Reset in cycle 2 of an N=4 run.
        @(negedge clk);
        cur_x      = 16'h3333;
        cur_w      = 16'h3333;
        start      = 1'b1;
        num_chunks = LEN_BW'(4);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("midrst ren before", int'(mem_ren), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst busy",   int'(busy),    0);
        check("midrst ren",    int'(mem_ren), 0);
        check("midrst result", int'(result),  0);
        check("midrst psum",   int'(psum_fb), 0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("midrst no done", int'(done),    0);
            check("midrst idle",    int'(busy),    0);
            check("midrst x_out",   int'(x_out),   0);
            check("midrst psum",    int'(psum_fb), 0);
        end
        run_vec("after_rst", 1, 16'h1111, 16'h1111, 4, 4, 0);

        // Reset and start in the same cycle: reset wins.
        @(negedge clk);
        reset      = 1'b1;
        start      = 1'b1;
        num_chunks = LEN_BW'(3);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("rst_start busy",  int'(busy),      0);
        check("rst_start state", int'(state_dbg), 0);
        @(negedge clk);
        check("rst_start ren",   int'(mem_ren),   0);
        check("rst_start busy2", int'(busy),      0);

`ifdef PSUM_INIT_EN
        psum_init = PSUM_BW'(100);
        run_vec("init_n1", 1, 16'h1111, 16'h1111, 104, 4, 0);
        run_vec("init_n0", 0, 16'h1111, 16'h1111, 100, 1, 0);
        psum_init = '0;
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
